// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register for a fetched word that the stalled pipeline
// could not accept yet.
module fetch_skid_buf #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc4_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;

  // Clear wins over load so a redirect always empties the entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear_i) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc4_d   = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF stage: PC, IF/ID register and variable-latency imem handshake.
// Optional FETCH_PERF_EN adds saturating stall/redirect counters.
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pc_write_i,
  input  logic               if_write_i,
  input  logic               if_flush_i,
  input  logic               pc_select_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o,
  output logic               if_id_valid_o,
  output logic               fetch_busy_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_stall_cnt_o,
  output logic [31:0]        perf_flush_cnt_o,
`endif
  output logic [1:0]         state_dbg_o
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic               skid_load, skid_clear, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc4;
  logic [ADDR_W-1:0]  pc_plus4;
  logic               xfer;

  // Handshake: req is held with a stable address until a cycle where
  // req & ready are both high; that cycle is the transfer and rdata is valid.
  assign imem_req_o   = ~rst_i & (state_q != S_HOLD);
  assign imem_addr_o  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign xfer         = imem_req_o & imem_ready_i;
  assign fetch_busy_o = imem_req_o & ~imem_ready_i;
  assign pc_plus4     = pc_q + ADDR_W'(PC_INC);

  fetch_skid_buf #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem_rdata_i),
    .pc4_i   (pc_plus4),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (pc_select_i) begin
      pc_d       = branch_target_i;
      instr_d    = INSTR_W'(NOP_INSTR);
      pc4_d      = '0;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      case (state_q)
        S_REQ: begin
          // An un-completed request must still finish on the old address.
          if (!xfer) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        S_DRAIN: state_d = xfer ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (xfer) begin
            if (!if_write_i) begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end else if (pc_write_i && !if_flush_i) begin
              instr_d = imem_rdata_i;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              pc_d    = pc_plus4;
            end else begin
              valid_d = 1'b0;
            end
          end else if (if_write_i) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (if_write_i && pc_write_i && skid_valid) begin
            instr_d    = skid_instr;
            pc4_d      = skid_pc4;
            valid_d    = 1'b1;
            pc_d       = pc_plus4;
            skid_clear = 1'b1;
            state_d    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (xfer) state_d = S_REQ;
          if (if_write_i) valid_d = 1'b0;
        end
        default: state_d = S_REQ;
      endcase
      if (if_flush_i) begin
        instr_d = INSTR_W'(NOP_INSTR);
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= INSTR_W'(NOP_INSTR);
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign state_dbg_o   = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if ((fetch_busy_o || state_q == S_HOLD) && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
    if (pc_select_i && perf_flush_q != 32'hFFFF_FFFF)
      perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl; memory returns the address as data.
module tb_fetch_stage_ctrl;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_write_i, if_write_i, if_flush_i, pc_select_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_instr_o, if_id_pc4_o;
  logic        if_id_valid_o, fetch_busy_o;
  logic [1:0]  state_dbg_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_w;

  assign imem_rdata_i = imem_addr_o;

  fetch_stage_ctrl #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_write_i      (pc_write_i),
    .if_write_i      (if_write_i),
    .if_flush_i      (if_flush_i),
    .pc_select_i     (pc_select_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_valid_o   (if_id_valid_o),
    .fetch_busy_o    (fetch_busy_o),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt_o(perf_stall_cnt_o),
    .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
    .state_dbg_o     (state_dbg_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver
  task automatic drive(input logic ps, input logic [31:0] tgt, input logic rdy,
                       input logic ifw, input logic pcw, input logic fl);
    pc_select_i     = ps;
    branch_target_i = tgt;
    imem_ready_i    = rdy;
    if_write_i      = ifw;
    pc_write_i      = pcw;
    if_flush_i      = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({imem_req_o, fetch_busy_o, if_id_valid_o, imem_addr_o, if_id_instr_o, if_id_pc4_o, state_dbg_o}
        !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, S_REQ}) begin
      errors++;
      $display("FAIL reset_state: req=%b busy=%b vld=%b addr=%h instr=%h pc4=%h st=%0d want 0,0,0,0,0,0,0",
               imem_req_o, fetch_busy_o, if_id_valid_o, imem_addr_o, if_id_instr_o, if_id_pc4_o, state_dbg_o);
    end
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk_i);
      checks++;
      if ({imem_req_o, fetch_busy_o, imem_addr_o} !== {1'b1, 1'b0, 32'(4 * i)}) begin
        errors++;
        $display("FAIL b2b_addr[%0d]: req=%b busy=%b addr=%h want 1,0,%h",
                 i, imem_req_o, fetch_busy_o, imem_addr_o, 32'(4 * i));
      end
      checks++;
      if (i == 0) begin
        if (if_id_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first_valid: got %b want 0", if_id_valid_o);
        end
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_ifid: scoreboard empty");
      end else begin
        exp_w = exp_q.pop_front();
        if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_w}) begin
          errors++;
          $display("FAIL b2b_ifid: got %b/%h/%h want 1/%h", if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_w);
        end
      end
      exp_q.push_back({32'(4 * i), 32'(4 * i + 4)});
      next_cycle();
    end
  endtask

  task automatic test_ready_delay();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, (i == 3), 1'b1, 1'b1, 1'b0);
      @(negedge clk_i);
      checks++;
      if ({imem_req_o, fetch_busy_o, imem_addr_o} !== {1'b1, (i != 3), 32'h10}) begin
        errors++;
        $display("FAIL delay_addr[%0d]: req=%b busy=%b addr=%h want 1,%b,00000010",
                 i, imem_req_o, fetch_busy_o, imem_addr_o, (i != 3));
      end
      checks++;
      if (i == 0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL delay_ifid: scoreboard empty");
        end else begin
          exp_w = exp_q.pop_front();
          if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_w}) begin
            errors++;
            $display("FAIL delay_ifid: got %b/%h/%h want 1/%h", if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_w);
          end
        end
      end else if (if_id_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL delay_bubble[%0d]: valid=%b want 0", i, if_id_valid_o);
      end
      if (i == 3) exp_q.push_back({32'h10, 32'h14});
      next_cycle();
    end
  endtask

  task automatic test_stall_hold();
    // Redirect with a simultaneous transfer just repositions the PC.
    drive(1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o} !== {1'b1, exp_w, 32'h14}) begin
      errors++;
      $display("FAIL delay_result: got %b/%h/%h addr=%h want 1/%h addr=00000014",
               if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o, exp_w);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({imem_req_o, if_id_valid_o, imem_addr_o} !== {1'b1, 1'b0, 32'h20}) begin
      errors++;
      $display("FAIL stall_xfer: req=%b vld=%b addr=%h want 1,0,00000020", imem_req_o, if_id_valid_o, imem_addr_o);
    end
    exp_q.push_back({32'h20, 32'h24});
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({imem_req_o, if_id_valid_o, state_dbg_o, if_id_instr_o} !== {1'b0, 1'b0, S_HOLD, 32'h0}) begin
      errors++;
      $display("FAIL stall_hold: req=%b vld=%b st=%0d instr=%h want 0,0,1,0", imem_req_o, if_id_valid_o, state_dbg_o, if_id_instr_o);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({imem_req_o, state_dbg_o} !== {1'b0, S_HOLD}) begin
      errors++;
      $display("FAIL stall_release_cycle: req=%b st=%0d want 0,1", imem_req_o, state_dbg_o);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_req_o, fetch_busy_o, imem_addr_o}
        !== {1'b1, exp_w, 1'b1, 1'b1, 32'h24}) begin
      errors++;
      $display("FAIL stall_unload: got %b/%h/%h req=%b busy=%b addr=%h want 1/%h 1,1,00000024",
               if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_req_o, fetch_busy_o, imem_addr_o, exp_w);
    end
    next_cycle();
  endtask

  task automatic test_redirect_drain();
    drive(1'b1, 32'h30, 1'b1, 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({imem_req_o, fetch_busy_o, imem_addr_o} !== {1'b1, 1'b1, 32'h30}) begin
      errors++;
      $display("FAIL drain_pending: req=%b busy=%b addr=%h want 1,1,00000030", imem_req_o, fetch_busy_o, imem_addr_o);
    end
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, (i == 2), 1'b1, 1'b1, 1'b0);
      @(negedge clk_i);
      checks++;
      if ({imem_req_o, fetch_busy_o, if_id_valid_o, state_dbg_o, imem_addr_o}
          !== {1'b1, (i != 2), 1'b0, S_DRAIN, 32'h30}) begin
        errors++;
        $display("FAIL drain_hold[%0d]: req=%b busy=%b vld=%b st=%0d addr=%h want 1,%b,0,2,00000030",
                 i, imem_req_o, fetch_busy_o, if_id_valid_o, state_dbg_o, imem_addr_o, (i != 2));
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({if_id_valid_o, state_dbg_o, imem_addr_o} !== {1'b0, S_REQ, 32'h100}) begin
      errors++;
      $display("FAIL drain_done: vld=%b st=%0d addr=%h want 0,0,00000100", if_id_valid_o, state_dbg_o, imem_addr_o);
    end
    exp_q.push_back({32'h100, 32'h104});
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o} !== {1'b1, exp_w, 32'h104}) begin
      errors++;
      $display("FAIL drain_target: got %b/%h/%h addr=%h want 1/%h addr=00000104",
               if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o, exp_w);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_addr: got %h want fffffffc", imem_addr_o);
    end
    exp_q.push_back({32'hFFFF_FFFC, 32'h0});
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o} !== {1'b1, exp_w, 32'h0}) begin
      errors++;
      $display("FAIL wrap_pc: got %b/%h/%h addr=%h want 1/%h addr=00000000",
               if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o, exp_w);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({if_id_valid_o, imem_addr_o} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL flush_xfer: vld=%b addr=%h want 0,00000000", if_id_valid_o, imem_addr_o);
    end
    exp_q.push_back({32'h0, 32'h4});
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    checks++;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_w}) begin
      errors++;
      $display("FAIL flush_refetch: got %b/%h/%h want 1/%h", if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_w);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o, state_dbg_o, imem_addr_o}
        !== {1'b0, 32'h0, 32'h0, S_REQ, 32'h4}) begin
      errors++;
      $display("FAIL flush_clear: vld=%b instr=%h pc4=%h st=%0d addr=%h want 0,0,0,0,00000004",
               if_id_valid_o, if_id_instr_o, if_id_pc4_o, state_dbg_o, imem_addr_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({state_dbg_o, imem_addr_o} !== {S_DRAIN, 32'h4}) begin
      errors++;
      $display("FAIL rst_pre_drain: st=%0d addr=%h want 2,00000004", state_dbg_o, imem_addr_o);
    end
    #2;
    rst_i = 1'b1;
    imem_ready_i = 1'b1;
    #1;
    checks++;
    if ({imem_req_o, if_id_valid_o, state_dbg_o, imem_addr_o} !== {1'b0, 1'b0, S_REQ, 32'h0}) begin
      errors++;
      $display("FAIL rst_async: req=%b vld=%b st=%0d addr=%h want 0,0,0,00000000",
               imem_req_o, if_id_valid_o, state_dbg_o, imem_addr_o);
    end
    next_cycle();
    rst_i = 1'b0;
    imem_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({imem_req_o, fetch_busy_o, if_id_valid_o, imem_addr_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_release: req=%b busy=%b vld=%b addr=%h want 1,1,0,00000000",
               imem_req_o, fetch_busy_o, if_id_valid_o, imem_addr_o);
    end
    next_cycle();
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) next_cycle();
    drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if ({perf_stall_cnt_o, perf_flush_cnt_o} !== {32'd3, 32'd1}) begin
      errors++;
      $display("FAIL perf_counts: stall=%0d flush=%0d want 3,1", perf_stall_cnt_o, perf_flush_cnt_o);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_ready_delay();
    test_stall_hold();
    test_redirect_drain();
    test_wrap();
    test_flush();
    test_reset_mid_drain();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
